// File: rtl/alu_result_fifo.sv
// Result FIFO behind the ALU: stores {y, cout, overflow, negative, zero} with a sticky overflow bit.
// One-cycle latency from push to head, with no bypass; in_ready depends on occupancy only and never on out_ready.
module alu_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_y,
    input  logic                     in_cout,
    input  logic                     in_overflow,
    input  logic                     in_negative,
    input  logic                     in_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic                     out_cout,
    output logic                     out_overflow,
    output logic                     out_negative,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sticky_ovf,
    input  logic                     clr_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 4;
    localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_sticky;

    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    assign in_ready  = (r_count < L_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Storage is left unreset; the head mux hides stale contents while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_y, in_cout, in_overflow, in_negative, in_zero};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A new overflow takes priority over a clear in the same cycle.
            if (w_push && in_overflow) begin
                r_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;
    assign {out_y, out_cout, out_overflow, out_negative, out_zero} = w_head;
    assign count      = r_count;
    assign sticky_ovf = r_sticky;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed scenarios followed by randomized traffic with mid-run resets.
module tb_alu_result_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_y = '0;
    logic             in_cout = 1'b0;
    logic             in_overflow = 1'b0;
    logic             in_negative = 1'b0;
    logic             in_zero = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_y;
    logic             out_cout;
    logic             out_overflow;
    logic             out_negative;
    logic             out_zero;
    logic [2:0]       count;
    logic             sticky_ovf;
    logic             clr_sticky = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    int         m_count = 0;
    logic       m_sticky = 1'b0;

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
        .in_cout(in_cout), .in_overflow(in_overflow),
        .in_negative(in_negative), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_cout(out_cout), .out_overflow(out_overflow),
        .out_negative(out_negative), .out_zero(out_zero),
        .count(count), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored entries plus an occupancy counter and sticky bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_count  = 0;
            m_sticky = 1'b0;
        end else begin
            logic acc_push;
            logic acc_pop;
            chk("count", 32'(count), 32'(m_count));
            chk("in_ready", 32'(in_ready), 32'(m_count < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(m_count != 0));
            chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
            if (m_count == 0)
                chk("empty_outputs", 32'({out_y, out_cout, out_overflow, out_negative, out_zero}), 32'd0);
            acc_push = in_valid && (m_count < DEPTH);
            acc_pop  = out_ready && (m_count > 0);
            if (acc_push)
                q.push_back({in_y, in_cout, in_overflow, in_negative, in_zero});
            m_count = m_count + (acc_push ? 1 : 0) - (acc_pop ? 1 : 0);
            if (acc_push && in_overflow)
                m_sticky = 1'b1;
            else if (clr_sticky)
                m_sticky = 1'b0;
        end
    end

    // Monitor: compares the presented head against the oldest expected entry; retires it on a pop.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("head_unexpected", 32'd1, 32'd0);
            end else begin
                chk("head", 32'({out_y, out_cout, out_overflow, out_negative, out_zero}), 32'(q[0]));
                if (out_ready)
                    void'(q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [3:0] y, input logic [3:0] f,
                        input logic rdy, input logic clr);
        in_valid   = v;
        in_y       = y;
        {in_cout, in_overflow, in_negative, in_zero} = f;
        out_ready  = rdy;
        clr_sticky = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_y", 32'(out_y), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("init_count", 32'(count), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 4'h0, 4'h0, 0, 0);

        // Single pass
        step(1, 4'b0010, 4'h0, 0, 0);
        chk("single_count", 32'(count), 32'd1);
        chk("single_y", 32'(out_y), 32'h2);
        step(0, 4'h0, 4'h0, 1, 0);
        chk("single_drained", 32'(count), 32'd0);
        chk("single_y_zero", 32'(out_y), 32'h0);

        // Fill, overfill, full simultaneous, drain
        step(1, 4'b0001, 4'h0, 0, 0);
        step(1, 4'b0110, 4'h0, 0, 0);
        step(1, 4'b1111, 4'b1010, 0, 0);
        step(1, 4'b0111, 4'b0001, 0, 0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step(1, 4'b0101, 4'h0, 0, 0);
        chk("overfill_count", 32'(count), 32'd4);
        step(1, 4'b1001, 4'h0, 1, 0);
        chk("full_simul_count", 32'(count), 32'd3);
        chk("full_simul_ready", 32'(in_ready), 32'd1);
        chk("full_simul_head", 32'(out_y), 32'b0110);
        for (int i = 0; i < 3; i++) step(0, 4'h0, 4'h0, 1, 0);
        chk("drained", 32'(count), 32'd0);

        // Empty simultaneous, then wrap under steady push/pop at count=2
        step(1, 4'hA, 4'h0, 1, 0);
        chk("empty_simul_count", 32'(count), 32'd1);
        step(1, 4'hB, 4'h0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 4'(i + 3), 4'(i), 1, 0);
            chk("wrap_count", 32'(count), 32'd2);
        end
        step(0, 4'h0, 4'h0, 1, 0);
        step(0, 4'h0, 4'h0, 1, 0);

        // Sticky overflow
        step(1, 4'h3, 4'b0100, 1, 0);
        chk("sticky_set", 32'(sticky_ovf), 32'd1);
        step(1, 4'h4, 4'b0100, 1, 1);
        chk("sticky_set_wins", 32'(sticky_ovf), 32'd1);
        step(0, 4'h0, 4'h0, 1, 1);
        chk("sticky_clear", 32'(sticky_ovf), 32'd0);

        // Async reset with three entries held
        step(1, 4'h1, 4'b0100, 0, 0);
        step(1, 4'h2, 4'h0, 0, 0);
        step(0, 4'h3, 4'h0, 0, 0);
        step(1, 4'h3, 4'h0, 0, 0);
        chk("pre_reset_count", 32'(count), 32'd3);
        step(0, 4'h0, 4'h0, 0, 0);
        async_reset();
        step(1, 4'b1100, 4'h0, 0, 0);
        chk("post_reset_y", 32'(out_y), 32'b1100);
        step(0, 4'h0, 4'h0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                step(0, 4'h0, 4'h0, 0, 0);
                async_reset();
            end
            step(1'($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < 6; i++) step(0, 4'h0, 4'h0, 1, 0);
        chk("final_empty", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
